// File: rtl/mulf_norm_round_if.sv
// Handshake bundle for the multiplier normalise/round stage.
// slave modport is the stage's view; master is the upstream/downstream driver.
interface mulf_norm_round_if #(
  parameter int PROD_W = 48,
  parameter int EXP_W  = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [PROD_W-1:0]       in_prod;
  logic [1:0]              in_class;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  logic [2:0]              out_flags;

  modport slave (
    input  in_valid, in_sign, in_exp, in_prod, in_class, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

  modport master (
    output in_valid, in_sign, in_exp, in_prod, in_class, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/mulf_norm_round.sv
// Normalise/round/pack stage behind the fp32 multiplier core.
// Stage 1 normalises the 48-bit product, stage 2 rounds, detects
// overflow/underflow (flush to zero) and applies class overrides.
// Build option: define MULF_ROUND_EN for round-to-nearest-even;
// otherwise the fraction is truncated (inexact still reported).
module mulf_norm_round #(
  parameter int PROD_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic clk,
  input  logic rst_n,
  mulf_norm_round_if.slave bus
);
  localparam int STAGES = 2;
  localparam logic [1:0] CLS_NORM = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic signed [EXP_W+1:0] EMAX = 255;

  typedef struct packed {
    logic                  sign;
    logic [1:0]            cls;
    logic [22:0]           frac;
    logic                  g;
    logic                  s;
    logic signed [EXP_W:0] e;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  logic            s2_adv;
  s1_t             s1_d, s1_q;
  logic [31:0]     res_d, res_q;
  logic [2:0]      flg_d, flg_q;

  // Stage 2 working values
  logic                    inc;
  logic [23:0]             fr_r;
  logic signed [EXP_W+1:0] e_r;
  logic                    uflow;

  assign s2_adv        = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready  = !vld_pipe[1] || s2_adv;
  assign bus.out_valid = vld_pipe[2];
  assign bus.out_result = res_q;
  assign bus.out_flags  = flg_q;

  // Normalise: the product of two [1,2) mantissas lies in [1,4), so at most a one-bit shift
  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_sign;
    s1_d.cls  = bus.in_class;
    s1_d.e    = {bus.in_exp[EXP_W-1], bus.in_exp}
              + {{EXP_W{1'b0}}, bus.in_prod[PROD_W-1]};
    if (bus.in_prod[PROD_W-1]) begin
      s1_d.frac = bus.in_prod[PROD_W-2 -: 23];
      s1_d.g    = bus.in_prod[PROD_W-25];
      s1_d.s    = |bus.in_prod[PROD_W-26:0];
    end else begin
      s1_d.frac = bus.in_prod[PROD_W-3 -: 23];
      s1_d.g    = bus.in_prod[PROD_W-26];
      s1_d.s    = |bus.in_prod[PROD_W-27:0];
    end
  end

  // Round, range-check and pack; class override wins over everything
  always_comb begin
`ifdef MULF_ROUND_EN
    inc = s1_q.g && (s1_q.s || s1_q.frac[0]);
`else
    inc = 1'b0;
`endif
    fr_r  = {1'b0, s1_q.frac} + {23'd0, inc};
    e_r   = {s1_q.e[EXP_W], s1_q.e} + {{(EXP_W+1){1'b0}}, fr_r[23]};
    // underflow looks at the exponent before any rounding carry
    uflow = s1_q.e[EXP_W] || (s1_q.e == '0);
    res_d = {s1_q.sign, e_r[7:0], fr_r[22:0]};
    flg_d = {2'b00, s1_q.g | s1_q.s};
    if (s1_q.cls == CLS_NORM) begin
      if (uflow) begin
        res_d = {s1_q.sign, 31'd0};
        flg_d = 3'b011;
      end else if (e_r >= EMAX) begin
        res_d = {s1_q.sign, 8'hFF, 23'd0};
        flg_d = 3'b101;
      end
    end else begin
      flg_d = 3'b000;
      if (s1_q.cls == CLS_ZERO)     res_d = {s1_q.sign, 31'd0};
      else if (s1_q.cls == CLS_INF) res_d = {s1_q.sign, 8'hFF, 23'd0};
      else                          res_d = 32'h7FC00000;
    end
  end

  // Pipeline registers: stage 1 refills when it empties or moves on, stage 2 holds under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      if (bus.in_ready) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          res_q <= res_d;
          flg_q <= flg_d;
        end
      end
    end
  end
endmodule
